// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
// The sweep FSM state type lives here so the controller and the storage agree on it.
package regfile_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 3;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_init_ctrl.sv
// Initialisation sweep controller: after reset, walks every address once and then parks in RUN.
// init_we/init_addr tell the storage which register to preload with its own index.
module regfile_init_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              init_busy,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr
);

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                INIT: begin
                    cnt_q <= cnt_q + ADDR_W'(1);
                    // The edge that writes the last register also leaves INIT.
                    if (&cnt_q) begin
                        state_q <= RUN;
                        busy_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign init_busy = busy_q;
    assign init_we   = (state_q == INIT);
    assign init_addr = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Two-read, one-write register file preloaded with r[i] = i after every reset.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter bit          R0_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rg_wr,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] data_out1,
    output logic [DATA_W-1:0] data_out2,
    output logic              init_busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              init_we;
    logic [ADDR_W-1:0] init_addr;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_val;

    regfile_init_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_init_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_busy (init_busy),
        .init_we   (init_we),
        .init_addr (init_addr)
    );

    // The sweep owns the write port in INIT; r0 preloads to 0 either way.
    always_comb begin
        wr_en   = rg_wr;
        wr_addr = write_reg;
        wr_val  = write_data;
        if (init_we) begin
            wr_en   = 1'b1;
            wr_addr = init_addr;
            wr_val  = DATA_W'(init_addr);
        end else if (R0_ZERO && write_reg == '0) begin
            wr_en = 1'b0;
        end
        if (!rst_n) begin
            wr_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_val;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = mem[addr];
`ifdef REGFILE_BYPASS_EN
        if (rg_wr && rst_n && addr == write_reg) begin
            val = write_data;
        end
`else
        // Without forwarding, a write becomes visible only after its edge.
`endif
        if (init_busy || (R0_ZERO && addr == '0)) begin
            val = '0;
        end
        return val;
    endfunction

    always_comb begin
        data_out1 = read_port(read_reg1);
        data_out2 = read_port(read_reg2);
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, reset corner cases and a random
// phase compared against an array model of the register file (plain and R0_ZERO instances).
module tb_regfile_mp;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int N  = 8;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rg_wr;
    logic [AW-1:0] write_reg;
    logic [DW-1:0] write_data;
    logic [AW-1:0] read_reg1;
    logic [AW-1:0] read_reg2;
    logic [DW-1:0] a_o1, a_o2, b_o1, b_o2;
    logic          a_busy, b_busy;

    regfile_mp #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .R0_ZERO (1'b0)
    ) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .rg_wr      (rg_wr),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .data_out1  (a_o1),
        .data_out2  (a_o2),
        .init_busy  (a_busy)
    );

    regfile_mp #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .R0_ZERO (1'b1)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .rg_wr      (rg_wr),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .data_out1  (b_o1),
        .data_out2  (b_o2),
        .init_busy  (b_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: register contents, sweep progress and busy flag.
    logic [DW-1:0] ma [N];
    logic [DW-1:0] mb [N];
    int            sweep;
    bit            mbusy;

    typedef struct {
        logic          wr;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] r1;
        logic [AW-1:0] r2;
        logic          busy;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Applies the effect of the coming clock edge to the model, from the inputs now driven.
    task automatic model_edge();
        if (!rst_n) begin
            sweep = 0;
            mbusy = 1'b1;
        end else if (mbusy) begin
            ma[sweep] = DW'(sweep);
            mb[sweep] = DW'(sweep);
            sweep++;
            if (sweep == N) mbusy = 1'b0;
        end else if (rg_wr) begin
            ma[write_reg] = write_data;
            if (write_reg != 0) mb[write_reg] = write_data;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] expect_rd(input bit r0z, input logic [AW-1:0] a);
        if (mbusy) return '0;
        if (r0z && a == 0) return '0;
        if (BYP && rg_wr && rst_n && a == write_reg) return write_data;
        return r0z ? mb[a] : ma[a];
    endfunction

    task automatic check_model(input string tag);
        chk({tag, " busy_a"}, 32'(a_busy), 32'(mbusy));
        chk({tag, " busy_b"}, 32'(b_busy), 32'(mbusy));
        chk({tag, " a_o1"}, 32'(a_o1), 32'(expect_rd(1'b0, read_reg1)));
        chk({tag, " a_o2"}, 32'(a_o2), 32'(expect_rd(1'b0, read_reg2)));
        chk({tag, " b_o1"}, 32'(b_o1), 32'(expect_rd(1'b1, read_reg1)));
        chk({tag, " b_o2"}, 32'(b_o2), 32'(expect_rd(1'b1, read_reg2)));
    endtask

    initial begin
        rst_n      = 1'b0;
        rg_wr      = 1'b0;
        write_reg  = '0;
        write_data = '0;
        read_reg1  = '0;
        read_reg2  = '0;
        sweep      = 0;
        mbusy      = 1'b1;

        // Directed table: sweep with an ignored write to r3, readback, write of BEEF to r5.
        for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, 3'd3, 16'h1234, 3'd3, 3'd0, 1'b1, 16'h0, 16'h0};
        tbl[8]  = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd1, 1'b0, 16'h0000, 16'h0001};
        tbl[9]  = '{1'b0, 3'd0, 16'h0000, 3'd2, 3'd3, 1'b0, 16'h0002, 16'h0003};
        tbl[10] = '{1'b0, 3'd0, 16'h0000, 3'd4, 3'd5, 1'b0, 16'h0004, 16'h0005};
        tbl[11] = '{1'b0, 3'd0, 16'h0000, 3'd6, 3'd7, 1'b0, 16'h0006, 16'h0007};
        tbl[12] = '{1'b1, 3'd5, 16'hBEEF, 3'd5, 3'd4, 1'b0, BYP ? 16'hBEEF : 16'h0005, 16'h0004};
        tbl[13] = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd5, 1'b0, 16'hBEEF, 16'hBEEF};

        step();
        step();
        chk("reset busy_a", 32'(a_busy), 32'd1);
        chk("reset busy_b", 32'(b_busy), 32'd1);
        chk("reset a_o1", 32'(a_o1), 32'd0);
        chk("reset a_o2", 32'(a_o2), 32'd0);

        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            rg_wr      = tbl[i].wr;
            write_reg  = tbl[i].wa;
            write_data = tbl[i].wd;
            read_reg1  = tbl[i].r1;
            read_reg2  = tbl[i].r2;
            #1;
            chk($sformatf("vec%0d busy", i), 32'(a_busy), 32'(tbl[i].busy));
            chk($sformatf("vec%0d o1", i), 32'(a_o1), 32'(tbl[i].e1));
            chk($sformatf("vec%0d o2", i), 32'(a_o2), 32'(tbl[i].e2));
            chk($sformatf("vec%0d b_o1", i), 32'(b_o1), 32'(expect_rd(1'b1, read_reg1)));
            step();
        end

        // r0 hardwiring: writes to r0 dropped, forwarding masked as well.
        rg_wr      = 1'b1;
        write_reg  = 3'd0;
        write_data = 16'hFFFF;
        read_reg1  = 3'd0;
        read_reg2  = 3'd0;
        #1;
        chk("r0 wrcyc b_o1", 32'(b_o1), 32'd0);
        chk("r0 wrcyc b_o2", 32'(b_o2), 32'd0);
        chk("r0 wrcyc a_o1", 32'(a_o1), BYP ? 32'hFFFF : 32'd0);
        step();
        rg_wr = 1'b0;
        #1;
        chk("r0 after b_o1", 32'(b_o1), 32'd0);
        chk("r0 after a_o1", 32'(a_o1), 32'hFFFF);
        step();

        // Random traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            rst_n      = ($urandom_range(0, 49) != 0);
            rg_wr      = 1'($urandom_range(0, 1));
            write_reg  = AW'($urandom_range(0, N - 1));
            write_data = DW'($urandom);
            read_reg1  = ($urandom_range(0, 3) == 0) ? write_reg : AW'($urandom_range(0, N - 1));
            read_reg2  = ($urandom_range(0, 3) == 0) ? read_reg1 : AW'($urandom_range(0, N - 1));
            #1;
            check_model($sformatf("rnd%0d", n));
            step();
        end

        // Reset for one cycle at sweep cycle 4 restarts the full sweep.
        rst_n = 1'b0;
        rg_wr = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step();
        rst_n = 1'b0;
        rg_wr = 1'b1;
        #1;
        chk("midreset busy", 32'(a_busy), 32'd1);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("resweep busy c%0d", k), 32'(a_busy), 32'd1);
            step();
        end
        rg_wr = 1'b0;
        #1;
        chk("resweep done", 32'(a_busy), 32'd0);
        for (int i = 0; i < N; i++) begin
            read_reg1 = AW'(i);
            read_reg2 = AW'(N - 1 - i);
            #1;
            chk($sformatf("resweep a r%0d", i), 32'(a_o1), 32'(i));
            chk($sformatf("resweep a2 r%0d", N - 1 - i), 32'(a_o2), 32'(N - 1 - i));
            chk($sformatf("resweep b r%0d", i), 32'(b_o1), 32'(i));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 16: register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3: address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter R0_ZERO, default 0: 1 = register 0 is hardwired to zero.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge active.
REQ-005 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port rg_wr, input, 1: write enable.
REQ-007 SHALL have port write_reg, input, ADDR_W: write address.
REQ-008 SHALL have port write_data, input, DATA_W: write data.
REQ-009 SHALL have ports read_reg1 and read_reg2, input, ADDR_W: read addresses.
REQ-010 SHALL have ports data_out1 and data_out2, output, DATA_W: read data.
REQ-011 SHALL have port init_busy, output, 1: high while the initialisation sweep runs.

Function
REQ-012 SHALL use a two-state FSM: INIT and RUN.
REQ-013 In INIT, SHALL write value i (zero-extended to DATA_W) into register i, one register per clk, with i running 0..DEPTH-1 from a counter.
REQ-014 SHALL move INIT->RUN on the edge that writes register DEPTH-1; the sweep takes exactly DEPTH cycles after reset release.
REQ-015 SHALL hold init_busy=1 in INIT and init_busy=0 in RUN.
REQ-016 SHALL ignore rg_wr in INIT; no write is queued or deferred.
REQ-017 SHALL drive data_out1/2 = 0 in INIT.
REQ-018 In RUN, when rg_wr=1, SHALL store write_data into write_reg on the clk rising edge.
REQ-019 In RUN, SHALL drive data_out1/2 combinationally from the addressed register (zero latency).
REQ-020 With R0_ZERO=1, SHALL return 0 for reads of address 0, drop writes to address 0, and write 0 to register 0 during INIT.
REQ-021 When both read ports address the same register, SHALL return identical data on both.

Reset
REQ-022 When rst_n=0 at a clk edge, SHALL enter INIT with the counter at 0, init_busy=1 and data_out1/2=0.
REQ-023 Reset asserted mid-sweep or in RUN SHALL restart the sweep from register 0; writes in that cycle are dropped.
REQ-024 SHALL have no asynchronous reset path; register contents before the first reset are undefined.

Configuration
REQ-025 With REGFILE_BYPASS_EN defined, in RUN, when rg_wr=1 and write_reg equals read_regN, data_outN SHALL equal write_data in the same cycle. R0_ZERO masking still applies.
REQ-026 Without REGFILE_BYPASS_EN, data_outN SHALL show the stored value, and the new value SHALL appear only after the write edge.

Structure
REQ-027 SHALL place the FSM state type (INIT, RUN) and the default DATA_W/ADDR_W constants in shared package regfile_pkg.
REQ-028 SHALL implement the FSM and sweep counter in sub-module regfile_init_ctrl. Its outputs: init_busy, init_we, init_addr.
REQ-029 The storage array and read muxing SHALL reside in regfile_mp.

Verification
REQ-030 Release rst_n with defaults -> init_busy high for 8 cycles, then low; reads of r0..r7 return 0..7.
REQ-031 In RUN, rg_wr=1, write_reg=5, write_data=16'hBEEF -> next cycle, read_reg1=5 returns BEEF; read_reg2=5 also returns BEEF.
REQ-032 Same write with read_reg1=5 in the write cycle -> BEEF in that cycle if REGFILE_BYPASS_EN is defined, else 5.
REQ-033 rg_wr=1, write_reg=3, data 16'h1234 during INIT -> after the sweep, r3 reads 3.
REQ-034 Assert rst_n=0 for one cycle at sweep cycle 4 -> init_busy stays high for 8 further cycles; all registers read i.
REQ-035 R0_ZERO=1: write 16'hFFFF to r0 -> r0 reads 0; a simultaneous bypass read also returns 0.
